lt100_timer: RTL and testbench
==============================

# lt100_timer

Memory-mapped 32-bit timer/compare peripheral that acts as a bus responder on the lt100 system bus, the target side of the core's `enable`/`ready` handshake. It decodes a 16-byte register window, performs byte-lane-correct reads and writes, and returns a one-cycle `ready` pulse per transaction. It raises a level `irq` on compare match and sits behind the bus decoder next to the UART and PWM targets.

## Interface
- `BASE_ADDR`, default 32'h0002_0000: window base; only `addr[31:4]` is compared.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  transaction request; initiator holds it and all request fields stable until it sees `ready`.
- `wr_en`  in  1  1 = write, 0 = read.
- `addr`  in  32  byte address.
- `i_data`  in  32  write data, LSB-aligned (byte lane 0 holds the byte written at `addr`).
- `be`  in  4  access width mask relative to `addr`: 0001 byte, 0011 half, 1111 word.
- `ready`  out  1  one-cycle completion pulse.
- `o_data`  out  32  read data, LSB-aligned: word >> (8*`addr[1:0]`); held until the next completion.
- `irq`  out  1  `STATUS.MATCH & CTRL.IE`.
- `bus_err`  out  1  error flag, valid only while `ready`=1.

## Operation
- Registers, at word offset `addr[3:2]`:
  - 0x0 CTRL: bit0 RUN, bit1 AUTO (clear on match), bit2 IE. Other bits read 0. Reset value 0.
  - 0x4 COUNT: R/W. Reset value 0.
  - 0x8 CMP: R/W. Reset value 0xFFFF_FFFF.
  - 0xC STATUS: bit0 MATCH; write-1-to-clear per byte lane. Reset value 0.
- Effective lane mask: `be << addr[1:0]`, computed at 7 bits. The access is an error and has no side effects if any of the following holds:
  - any of mask bits 6:4 is set;
  - `be` == 0;
  - `addr[31:4]` != `BASE_ADDR[31:4]`.
- On error, `o_data` is set to 0 and `bus_err`=1 with `ready`.
- Writes update only the bytes whose lanes are set in the mask. Byte n of the register takes `i_data[8*(n-addr[1:0]) +: 8]`. Reads ignore `be` and return the shifted word.
- Tick: 1 every cycle while RUN=1.
- On tick:
  - if COUNT == CMP: set MATCH, and COUNT <= AUTO ? 0 : COUNT+1;
  - otherwise COUNT <= COUNT+1, wrapping 0xFFFF_FFFF → 0.
- Priorities:
  - A bus write to COUNT in the same cycle as a tick wins over the increment.
  - A match set wins over a same-cycle W1C.
  - A CMP write takes effect for the next tick compare.
- `irq` is combinational from registered MATCH and IE only; it has no added latency.

## Timing
- FSM states:
  - IDLE: `enable`=1 latches `wr_en`, `addr`, `i_data`, `be` → ACCESS.
  - ACCESS: performs decode, the write or read capture, and loads `o_data` and `bus_err`; sets `ready`=1 → RESP.
  - RESP: clears `ready` and `bus_err`. Goes to HOLD if `enable`=1, else IDLE.
  - HOLD: waits for `enable`=0 → IDLE.
- Latency: `enable` sampled at edge k, `ready` high during cycle k+1..k+2, register write visible from edge k+1.
- Each transaction needs at least one `enable`-low cycle before the next one is accepted, so a held `enable` never double-executes.
- If `enable` drops during ACCESS, the transaction still completes and `ready` still pulses.
- `rst` at any time forces IDLE, clears `ready`, `bus_err` and `o_data` to 0, and resets all registers. Any in-flight write is lost.

## Configuration
- `LT100_TIMER_PRESCALE_EN` defined:
  - CTRL[15:8] is PRESCALE (R/W, reset 0); a tick occurs every PRESCALE+1 cycles while RUN=1.
  - The prescale counter clears when RUN=0 or on any CTRL write.
- `LT100_TIMER_PRESCALE_EN` undefined:
  - CTRL[15:8] reads 0 and ignores writes; tick every cycle while RUN=1.

## Test plan
- Word write 0x0000_0010 to CMP (0x8), then read 0x8 with `be`=1111 → `ready` 2 cycles after `enable`, `o_data`=0x0000_0010, `bus_err`=0. `enable` held 5 extra cycles yields exactly one `ready`.
- Byte write `i_data`=0xAB at `addr` 0x5 with `be`=0001 over COUNT=0 (RUN=0) → COUNT reads 0x0000_AB00. Half read at 0x5 returns `o_data`[15:0]=0x00AB.
- CTRL=0x7, CMP=3 → MATCH and `irq` set on the tick where COUNT=3, COUNT then 0. A W1C of 0x1 to STATUS drops `irq` the cycle after ACCESS.
- Half access at 0x7 (mask overflow), `addr` 0x0003_0000, and `be`=0000 → each gives `ready`+`bus_err`=1, `o_data`=0, with no register change.
- COUNT write 0x0000_0100 coincident with a tick → COUNT=0x0000_0100, not 0x101. Assert `rst` during ACCESS → `ready` stays 0 and CMP reads 0xFFFF_FFFF.
- With `LT100_TIMER_PRESCALE_EN`, PRESCALE=4, RUN=1 → COUNT increments once per 5 cycles. Without the macro, a write of 0x0000_0401 to CTRL reads back as 0x0000_0001.

Source files
------------

// File: rtl/lt100_timer.sv
// lt100_timer: 32-bit timer/compare bus responder on the lt100 system bus.
//
// Decodes a 16-byte window at BASE_ADDR (only addr[31:4] compared) holding
// CTRL (0x0), COUNT (0x4), CMP (0x8) and STATUS (0xC). Each accepted request
// completes with a one-cycle ready pulse two edges after enable is sampled.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   enable   transaction request, held with its fields until ready
//   wr_en    1 = write, 0 = read
//   addr     byte address
//   i_data   write data, LSB-aligned to addr
//   be       access width mask relative to addr
//   ready    one-cycle completion pulse
//   o_data   read data, LSB-aligned, held until the next completion
//   irq      STATUS.MATCH & CTRL.IE (combinational from registers)
//   bus_err  error flag, valid while ready
//
// Build option: define LT100_TIMER_PRESCALE_EN to enable CTRL[15:8] PRESCALE.

module lt100_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] o_data,
    output logic        irq,
    output logic        bus_err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANE_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_latch;
    logic   w_access;

    logic              r_wr_en;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;

    logic              r_run;
    logic              r_auto;
    logic              r_ie;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_cmp;
    logic              r_match;

    logic [1:0]        w_off;
    logic [1:0]        w_sel;
    logic [6:0]        w_mask;
    logic [3:0]        w_lanes;
    logic              w_err;
    logic              w_wr_ok;
    logic              w_ctrl_wr;
    logic              w_count_wr;
    logic              w_cmp_wr;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rdata_sh;
    logic [DATA_W-1:0] w_count_nxt;
    logic              w_match_set;
    logic              w_match_clr;
    logic              w_tick;
    logic [7:0]        w_presc_rd;

    // Replace the bytes of old_w selected by lanes with those of new_w.
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [3:0]        lanes);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int n = 0; n < int'(LANE_N); n++) begin
            if (lanes[n]) res[8*n +: 8] = new_w[8*n +: 8];
        end
        return res;
    endfunction

    // Handshake FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Handshake FSM: next state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = enable ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!enable) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture so a dropped enable still completes the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_latch) begin
            r_wr_en <= wr_en;
            r_addr  <= addr;
            r_wdata <= i_data;
            r_be    <= be;
        end
    end

    // Address decode, lane mask and error detection.
    always_comb begin
        w_off      = r_addr[1:0];
        w_sel      = r_addr[3:2];
        w_mask     = 7'(r_be) << w_off;
        w_lanes    = w_mask[3:0];
        w_err      = (|w_mask[6:4]) || (r_be == 4'd0) ||
                     (r_addr[31:4] != BASE_ADDR[31:4]);
        w_wr_ok    = w_access && r_wr_en && !w_err;
        w_ctrl_wr  = w_wr_ok && (w_sel == 2'd0);
        w_count_wr = w_wr_ok && (w_sel == 2'd1);
        w_cmp_wr   = w_wr_ok && (w_sel == 2'd2);
        w_wdata_sh = r_wdata << {w_off, 3'b000};
    end

`ifdef LT100_TIMER_PRESCALE_EN
    logic [7:0] r_presc;
    logic [7:0] r_pre_cnt;

    // Prescaler restarts on RUN=0 or any CTRL write so a new ratio starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_pre_cnt <= '0;
        end else begin
            if (w_ctrl_wr && w_lanes[1]) r_presc <= w_wdata_sh[15:8];
            if (w_ctrl_wr || !r_run || w_tick) r_pre_cnt <= '0;
            else                               r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end

    assign w_tick     = r_run && (r_pre_cnt == r_presc);
    assign w_presc_rd = r_presc;
`else
    assign w_tick     = r_run;
    assign w_presc_rd = 8'h00;
`endif

    // Register read mux.
    always_comb begin
        w_rd_word = '0;
        case (w_sel)
            2'd0:    w_rd_word = {16'h0000, w_presc_rd, 5'b00000, r_ie, r_auto, r_run};
            2'd1:    w_rd_word = r_count;
            2'd2:    w_rd_word = r_cmp;
            default: w_rd_word = {31'd0, r_match};
        endcase
        w_rdata_sh = w_rd_word >> {w_off, 3'b000};
    end

    // Counter step and match; a bus write to COUNT overrides the tick.
    always_comb begin
        w_count_nxt = r_count;
        w_match_set = 1'b0;
        if (w_tick) begin
            if (r_count == r_cmp) begin
                w_match_set = 1'b1;
                w_count_nxt = r_auto ? '0 : r_count + 32'd1;
            end else begin
                w_count_nxt = r_count + 32'd1;
            end
        end
        if (w_count_wr) w_count_nxt = f_merge(r_count, w_wdata_sh, w_lanes);
        w_match_clr = w_wr_ok && (w_sel == 2'd3) && w_lanes[0] && w_wdata_sh[0];
    end

    // Timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_auto  <= 1'b0;
            r_ie    <= 1'b0;
            r_count <= '0;
            r_cmp   <= '1;
            r_match <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_match <= (r_match && !w_match_clr) || w_match_set;
            if (w_ctrl_wr && w_lanes[0]) begin
                r_run  <= w_wdata_sh[0];
                r_auto <= w_wdata_sh[1];
                r_ie   <= w_wdata_sh[2];
            end
            if (w_cmp_wr) r_cmp <= f_merge(r_cmp, w_wdata_sh, w_lanes);
        end
    end

    // Response: ready pulse, error flag and read data; writes leave o_data alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready   <= 1'b0;
            bus_err <= 1'b0;
            o_data  <= '0;
        end else begin
            ready   <= w_access;
            bus_err <= w_access && w_err;
            if (w_access) begin
                if (w_err)         o_data <= '0;
                else if (!r_wr_en) o_data <= w_rdata_sh;
            end
        end
    end

    assign irq = r_match && r_ie;

endmodule

// File: tb/tb_lt100_timer.sv
`timescale 1ns/1ps
module tb_lt100_timer;

    localparam logic [31:0] BASE = 32'h0002_0000;
`ifdef LT100_TIMER_PRESCALE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] i_data = 32'd0;
    logic [3:0]  be = 4'd0;
    logic        ready;
    logic [31:0] o_data;
    logic        irq;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    lt100_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .addr(addr),
        .i_data(i_data), .be(be), .ready(ready), .o_data(o_data), .irq(irq),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Registers as plain values; a transaction posted by the driver is applied
    // on the edge where the peripheral performs its access.
    logic [31:0] m_count = 32'd0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic        m_run = 1'b0, m_auto = 1'b0, m_ie = 1'b0, m_match = 1'b0;
    logic [7:0]  m_presc = 8'd0;
    int          m_pre = 0;
    logic        m_ready = 1'b0, m_err = 1'b0;
    logic [31:0] m_odata = 32'd0;
    int          m_done = 0;

    // transaction posted by the driver
    int          p_id = 0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = 32'd0, p_data = 32'd0;
    logic [3:0]  p_be = 4'd0;

    logic [31:0] t_cnt, t_rw;
    bit          t_tick, t_set, t_clr, t_err, t_ctrlwr, t_run_old;
    int          t_off, t_mask, t_word;
    logic [7:0]  t_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
            m_run = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_match = 1'b0;
            m_presc = 8'd0; m_pre = 0;
            m_ready = 1'b0; m_err = 1'b0; m_odata = 32'd0;
            m_done = p_id;
        end else begin
            t_run_old = m_run;
            t_tick = m_run && (!PRE_EN || m_pre == int'(m_presc));
            t_set = 1'b0; t_clr = 1'b0; t_ctrlwr = 1'b0;
            t_cnt = m_count;
            if (t_tick) begin
                if (m_count == m_cmp) begin
                    t_set = 1'b1;
                    t_cnt = m_auto ? 32'd0 : m_count + 32'd1;
                end else begin
                    t_cnt = m_count + 32'd1;
                end
            end
            m_ready = 1'b0;
            if (p_id != m_done) begin
                m_done  = p_id;
                m_ready = 1'b1;
                t_off  = int'(p_addr[1:0]);
                t_mask = int'(p_be) * (1 << t_off);
                t_word = int'(p_addr[3:2]);
                t_err  = (t_mask >= 16) || (p_be == 4'd0) || ((p_addr >> 4) != (BASE >> 4));
                m_err  = t_err;
                if (t_err) begin
                    m_odata = 32'd0;
                end else if (p_we) begin
                    if (t_word == 1) t_cnt = m_count;
                    if (t_word == 0) t_ctrlwr = 1'b1;
                    for (int n = 0; n < 4; n++) begin
                        if (t_mask[n]) begin
                            t_b = p_data[8*(n-t_off) +: 8];
                            case (t_word)
                                0: begin
                                    if (n == 0) begin
                                        m_run = t_b[0]; m_auto = t_b[1]; m_ie = t_b[2];
                                    end
                                    if (n == 1 && PRE_EN) m_presc = t_b;
                                end
                                1: t_cnt[8*n +: 8] = t_b;
                                2: m_cmp[8*n +: 8] = t_b;
                                default: if (n == 0 && t_b[0]) t_clr = 1'b1;
                            endcase
                        end
                    end
                end else begin
                    case (t_word)
                        0: t_rw = {16'h0, (PRE_EN ? m_presc : 8'h00), 5'd0, m_ie, m_auto, m_run};
                        1: t_rw = m_count;
                        2: t_rw = m_cmp;
                        default: t_rw = {31'd0, m_match};
                    endcase
                    m_odata = t_rw >> (8 * t_off);
                end
            end
            if (!PRE_EN || t_ctrlwr || !t_run_old || t_tick) m_pre = 0;
            else m_pre = m_pre + 1;
            m_count = t_cnt;
            m_match = (m_match && !t_clr) || t_set;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(m_ready));
        chk("irq", 32'(irq), 32'(m_match && m_ie));
        chk("o_data", o_data, m_odata);
        if (m_ready) chk("bus_err", 32'(bus_err), 32'(m_err));
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int hold, input bit drop,
                        output logic [31:0] rd, output logic er);
        @(negedge clk);
        enable = 1'b1; wr_en = we; addr = a; i_data = d; be = b;
        @(posedge clk);
        @(negedge clk);
        p_we = we; p_addr = a; p_data = d; p_be = b;
        p_id = p_id + 1;
        if (drop) begin
            enable = 1'b0; wr_en = 1'($urandom); addr = $urandom; i_data = $urandom; be = 4'($urandom);
        end
        @(posedge clk);
        @(negedge clk);
        rd = o_data; er = bus_err;
        repeat (hold) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd; logic er;
        xfer(1'b1, a, d, b, 0, 1'b0, rd, er);
    endtask

    logic [31:0] rdv;
    logic        erv;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // CMP word write, read back with held enable
        wr(BASE + 32'h8, 32'h0000_0010, 4'hF);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 5, 1'b0, rdv, erv);
        chk("cmp_read", rdv, 32'h0000_0010);
        chk("cmp_read_err", 32'(erv), 32'd0);

        // byte lane write into COUNT, then word and half reads
        wr(BASE + 32'h5, 32'h0000_00AB, 4'h1);
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("count_byte_write", rdv, 32'h0000_AB00);
        xfer(1'b0, BASE + 32'h5, 32'd0, 4'h3, 0, 1'b1, rdv, erv);
        chk("half_read", 32'(rdv[15:0]), 32'h0000_00AB);

        // compare match with AUTO and IE, then W1C
        wr(BASE + 32'h4, 32'd0, 4'hF);
        wr(BASE + 32'h8, 32'd3, 4'hF);
        wr(BASE + 32'h0, 32'h7, 4'hF);
        repeat (12) @(negedge clk);
        chk("irq_after_match", 32'(irq), 32'd1);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("status_match", rdv, 32'd1);
        wr(BASE + 32'h0, 32'h6, 4'h1);
        wr(BASE + 32'hC, 32'h1, 4'h1);
        chk("irq_after_w1c", 32'(irq), 32'd0);

        // error accesses
        xfer(1'b1, BASE + 32'h7, 32'h0000_FFFF, 4'h3, 0, 1'b0, rdv, erv);
        chk("err_overflow", 32'(erv), 32'd1);
        chk("err_overflow_data", rdv, 32'd0);
        xfer(1'b1, 32'h0003_0000, 32'h1234_5678, 4'hF, 0, 1'b0, rdv, erv);
        chk("err_window", 32'(erv), 32'd1);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'h0, 0, 1'b0, rdv, erv);
        chk("err_be0", 32'(erv), 32'd1);
        chk("err_be0_data", rdv, 32'd0);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("cmp_unchanged", rdv, 32'd3);

        // COUNT write coincident with a tick
        wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        wr(BASE + 32'h0, 32'h1, 4'hF);
        wr(BASE + 32'h4, 32'h0000_0100, 4'hF);
        wr(BASE + 32'h0, 32'h0, 4'hF);
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("count_write_wins", rdv, 32'h0000_0104);

        // reset while a CMP write is in ACCESS
        @(negedge clk);
        enable = 1'b1; wr_en = 1'b1; addr = BASE + 32'h8; i_data = 32'h55; be = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("ready_in_reset", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("cmp_after_reset", rdv, 32'hFFFF_FFFF);

        // PRESCALE field
        wr(BASE + 32'h4, 32'd0, 4'hF);
        wr(BASE + 32'h0, 32'h0000_0401, 4'hF);
        xfer(1'b0, BASE + 32'h0, 32'd0, 4'hF, 0, 1'b0, rdv, erv);
        chk("ctrl_prescale", rdv, PRE_EN ? 32'h0000_0401 : 32'h0000_0001);
        repeat (10) @(negedge clk);
        wr(BASE + 32'h0, 32'h0, 4'hF);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a, d;
            logic [3:0]  b;
            bit          we;
            int          sel;
            we = 1'($urandom);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + 32'($urandom_range(0, 15));
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1: b = 4'h1;
                2, 3: b = 4'h3;
                4, 5: b = 4'hF;
                6:    b = 4'h0;
                default: b = 4'($urandom);
            endcase
            d = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 12));
            xfer(we, a, d, b, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rdv, erv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
